// File: rtl/full_subtractor_unit.sv
// One-bit full subtractor (in1 - in2 - in3) with a combinational result path
// and a registered path that can chain borrows bit-serially, LSB first.
module full_subtractor_unit (
  input  logic clk,
  input  logic rst,
  input  logic in1,
  input  logic in2,
  input  logic in3,
  input  logic in_valid,
  input  logic serial_en,
  input  logic serial_start,
  output logic Diff,
  output logic Borrow,
  output logic Diff_q,
  output logic Borrow_q,
  output logic out_valid
);

  // Handshake: in_valid qualifies in1/in2/in3 at the rising edge; there is no
  // ready, every valid beat is accepted. out_valid marks the beat registered
  // on the previous edge and is never stalled.

  logic bin;
  logic diff_next;
  logic borrow_next;

  assign Diff   = in1 ^ in2 ^ in3;
  assign Borrow = (~in1 & in2) | (~in1 & in3) | (in2 & in3);

  // The registered borrow is the serial chain state; serial_start restarts
  // the chain from in3 on the LSB.
  assign bin         = (serial_en && !serial_start) ? Borrow_q : in3;
  assign diff_next   = in1 ^ in2 ^ bin;
  assign borrow_next = (~in1 & in2) | (~in1 & bin) | (in2 & bin);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Diff_q    <= 1'b0;
      Borrow_q  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Diff_q   <= diff_next;
        Borrow_q <= borrow_next;
      end
    end
  end

endmodule

// File: tb/tb_full_subtractor_unit.sv
// Directed bench for full_subtractor_unit: truth table, parallel and serial
// registered paths, async reset and in_valid gaps, checked via a scoreboard.
module tb_full_subtractor_unit;

  logic clk = 1'b0;
  logic rst;
  logic in1, in2, in3, in_valid, serial_en, serial_start;
  logic Diff, Borrow, Diff_q, Borrow_q, out_valid;

  int total = 0;
  int bad = 0;

  logic [2:0] exp_q[$];
  logic m_ov, m_d, m_b;
  logic [1:0] tt [8];

  full_subtractor_unit dut (
    .clk(clk), .rst(rst), .in1(in1), .in2(in2), .in3(in3),
    .in_valid(in_valid), .serial_en(serial_en), .serial_start(serial_start),
    .Diff(Diff), .Borrow(Borrow), .Diff_q(Diff_q), .Borrow_q(Borrow_q),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  // Reference model of the registered path, built on integer subtraction.
  task automatic model_step(input logic v, input logic i1, input logic i2,
                            input logic i3, input logic se, input logic ss);
    logic b_in;
    int r;
    if (rst) begin
      m_ov = 1'b0; m_d = 1'b0; m_b = 1'b0;
    end else if (v) begin
      b_in = (se && !ss) ? m_b : i3;
      r = int'(i1) - int'(i2) - int'(b_in);
      m_d = r[0];
      m_b = (r < 0);
      m_ov = 1'b1;
    end else begin
      m_ov = 1'b0;
    end
    exp_q.push_back({m_ov, m_d, m_b});
  endtask

  task automatic step(input logic v, input logic i1, input logic i2,
                      input logic i3, input logic se, input logic ss);
    logic [2:0] e;
    in_valid = v; in1 = i1; in2 = i2; in3 = i3; serial_en = se; serial_start = ss;
    model_step(v, i1, i2, i3, se, ss);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 4'd1, 4'd0);
    end else begin
      e = exp_q.pop_front();
      check("registered", {1'b0, out_valid, Diff_q, Borrow_q}, {1'b0, e});
    end
  endtask

  task automatic serial_sub(input logic [3:0] a, input logic [3:0] b, input int gap_after);
    logic [3:0] res;
    logic [4:0] full;
    res = 4'd0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, a[i], b[i], 1'b0, 1'b1, (i == 0));
      res[i] = Diff_q;
      if (i == gap_after) begin
        for (int g = 0; g < 3; g++)
          step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'b1, 1'b0);
      end
    end
    full = {1'b0, a} - {1'b0, b};
    check("serial_result", res, full[3:0]);
    check("serial_borrow", {3'b0, Borrow_q}, {3'b0, (a < b)});
  endtask

  initial begin
    tt = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};
    rst = 1'b1;
    in1 = 0; in2 = 0; in3 = 0; in_valid = 0; serial_en = 0; serial_start = 0;
    m_ov = 0; m_d = 0; m_b = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {1'b0, out_valid, Diff_q, Borrow_q}, 4'b0000);

    // Combinational path is independent of reset; walk it while rst is held.
    for (int k = 0; k < 8; k++) begin
      logic [2:0] kv;
      kv = 3'(k);
      {in1, in2, in3} = kv;
      #1;
      check($sformatf("comb_%b", kv), {2'b00, Diff, Borrow}, {2'b00, tt[k]});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Parallel registered beat.
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("parallel_101", {1'b0, out_valid, Diff_q, Borrow_q}, 4'b0100);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

    serial_sub(4'b0101, 4'b0011, -1);
    serial_sub(4'b0010, 4'b0101, -1);

    // Async reset between edges with Borrow_q=1.
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", {1'b0, out_valid, Diff_q, Borrow_q}, 4'b0000);
    {in1, in2, in3} = 3'b011;
    #1;
    check("comb_in_reset", {2'b00, Diff, Borrow}, 4'b0001);
    model_step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    void'(exp_q.pop_back());
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    #1;
    rst = 1'b0;
    // No serial_start: borrow-in must come from the cleared state.
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check("post_reset_bin0", {1'b0, out_valid, Diff_q, Borrow_q}, 4'b0110);

    // Serial subtraction with an in_valid gap mid-operand.
    serial_sub(4'b0100, 4'b0110, 1);
    serial_sub(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2);
    serial_sub(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 0);

    check("scoreboard_drained", 4'(exp_q.size()), 4'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
